// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar receive chain: scan FSM states,
// sample format constants and the strobe divider derivation.
package sonar_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_DWELL   = 3'd2,
        S_COMPARE = 3'd3,
        S_DONE    = 3'd4
    } scan_state_t;

    localparam int SAMPLE_WIDTH    = 16;
    localparam int SAMPLE_MIDPOINT = 32768;

    // Clock cycles per sample strobe.
    function automatic int calc_max_count(input int clk_freq, input int sampling_rate);
        return clk_freq / sampling_rate;
    endfunction

endpackage

// File: rtl/beam_energy_acc.sv
// Absolute-deviation energy integrator. Each enabled cycle adds
// |sample - midpoint| into a saturating accumulator; clear has priority.
module beam_energy_acc
    import sonar_pkg::*;
#(
    parameter int ACC_WIDTH = 32
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    clear_in,
    input  logic                    enable_in,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    output logic [ACC_WIDTH-1:0]    sum_out
);

    localparam logic [SAMPLE_WIDTH-1:0] MIDPOINT = SAMPLE_WIDTH'(SAMPLE_MIDPOINT);

    logic [SAMPLE_WIDTH-1:0] dev;
    logic [ACC_WIDTH:0]      sum_wide;
    logic [ACC_WIDTH-1:0]    sum_reg;

    // Distance from the offset-binary midpoint; 0 maps to 32768, which still fits.
    always_comb begin
        if (sample_in >= MIDPOINT) begin
            dev = sample_in - MIDPOINT;
        end else begin
            dev = MIDPOINT - sample_in;
        end
    end

    assign sum_wide = {1'b0, sum_reg} + {{(ACC_WIDTH + 1 - SAMPLE_WIDTH){1'b0}}, dev};

    // Accumulate with saturation at all-ones so energy never wraps.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            sum_reg <= '0;
        end else if (clear_in) begin
            sum_reg <= '0;
        end else if (enable_in) begin
            sum_reg <= sum_wide[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_wide[ACC_WIDTH-1:0];
        end
    end

    assign sum_out = sum_reg;

endmodule

// File: rtl/beam_scan_scheduler.sv
// Receive beam sweep controller: sample strobe divider, steering angle
// stepping, settle/dwell sequencing and peak-energy tracking.
// Optional SCAN_BOTH_SIDES_EN extends the sweep onto side 1 (steps 1..N-1).
module beam_scan_scheduler
    import sonar_pkg::*;
#(
    parameter int CLK_FREQ       = 100000000,
    parameter int SAMPLING_RATE  = 1000000,
    parameter int NUM_STEPS      = 16,
    parameter int SIN_WIDTH      = 17,
    parameter int SETTLE_SAMPLES = 80,
    parameter int DWELL_SAMPLES  = 1024,
    parameter int ACC_WIDTH      = 32
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         start_in,
    input  logic                         abort_in,
    input  logic [SAMPLE_WIDTH-1:0]      beam_sample_in,
    output logic                         sample_tick_out,
    output logic [SIN_WIDTH-1:0]         sin_theta_out,
    output logic                         sign_bit_out,
    output logic                         busy_out,
    output logic                         result_valid_out,
    output logic [$clog2(NUM_STEPS)-1:0] best_step_out,
    output logic                         best_sign_out,
    output logic [ACC_WIDTH-1:0]         best_energy_out
);

    localparam int MAX_COUNT = calc_max_count(CLK_FREQ, SAMPLING_RATE);
    localparam int DIV_W     = $clog2(MAX_COUNT);
    localparam int STEP_W    = $clog2(NUM_STEPS);
    localparam int SIN_SHIFT = SIN_WIDTH - 1 - STEP_W;
    localparam int PHASE_MAX = (SETTLE_SAMPLES > DWELL_SAMPLES) ? SETTLE_SAMPLES : DWELL_SAMPLES;
    localparam int CNT_W     = $clog2(PHASE_MAX + 1);
    localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(NUM_STEPS - 1);

    scan_state_t state_reg, state_next;

    logic [DIV_W-1:0]     div_cnt_reg;
    logic                 tick;
    logic [CNT_W-1:0]     phase_cnt_reg;
    logic                 dwell_capture_reg;
    logic                 capture_en;
    logic                 start_go;
    logic                 settle_last;
    logic                 dwell_last;
    logic                 last_angle;
    logic                 acc_clear;
    logic [ACC_WIDTH-1:0] acc_sum;

    logic [STEP_W-1:0]    step_reg;
    logic                 side_reg;
    logic [ACC_WIDTH-1:0] run_best_energy_reg;
    logic [STEP_W-1:0]    run_best_step_reg;
    logic                 run_best_side_reg;
    logic                 win;
    logic [ACC_WIDTH-1:0] new_best_energy;
    logic [STEP_W-1:0]    new_best_step;
    logic                 new_best_side;
    logic [STEP_W-1:0]    best_step_reg;
    logic                 best_sign_reg;
    logic [ACC_WIDTH-1:0] best_energy_reg;

    // Free-running strobe divider, independent of the FSM.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            div_cnt_reg <= '0;
        end else if (div_cnt_reg == DIV_W'(MAX_COUNT - 1)) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

    assign tick            = (div_cnt_reg == DIV_W'(MAX_COUNT - 1));
    assign sample_tick_out = tick;

    assign start_go    = start_in && !abort_in;
    assign settle_last = tick && (phase_cnt_reg == CNT_W'(SETTLE_SAMPLES - 1));
    // Only strobes issued while in DWELL are integrated, one cycle later,
    // so the strobe that ends SETTLE is dropped even though it lands in DWELL.
    assign capture_en  = (state_reg == S_DWELL) && dwell_capture_reg;
    assign dwell_last  = capture_en && (phase_cnt_reg == CNT_W'(DWELL_SAMPLES - 1));
    assign acc_clear   = ((state_reg == S_IDLE) && start_go) || (state_reg == S_COMPARE);

`ifdef SCAN_BOTH_SIDES_EN
    // Side switches after side 0 finishes; step 0 is not revisited on side 1.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            side_reg <= 1'b0;
        end else if ((state_reg == S_IDLE) && start_go) begin
            side_reg <= 1'b0;
        end else if ((state_reg == S_COMPARE) && !abort_in && !last_angle && (step_reg == STEP_MAX)) begin
            side_reg <= 1'b1;
        end
    end
    assign last_angle = side_reg && (step_reg == STEP_MAX);
`else
    assign side_reg   = 1'b0;
    assign last_angle = (step_reg == STEP_MAX);
`endif

    // FSM state register.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic; abort overrides everything outside IDLE.
    always_comb begin
        state_next = state_reg;
        if (state_reg != S_IDLE && abort_in) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE:    if (start_go) state_next = S_SETTLE;
                S_SETTLE:  if (settle_last) state_next = S_DWELL;
                S_DWELL:   if (dwell_last) state_next = S_COMPARE;
                S_COMPARE: state_next = last_angle ? S_DONE : S_SETTLE;
                S_DONE:    state_next = S_IDLE;
                default:   state_next = S_IDLE;
            endcase
        end
    end

    // FSM outputs decoded from the registered state.
    always_comb begin
        busy_out         = (state_reg != S_IDLE);
        result_valid_out = (state_reg == S_DONE);
    end

    // Strobe counting within SETTLE/DWELL and the delayed capture qualifier.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            phase_cnt_reg     <= '0;
            dwell_capture_reg <= 1'b0;
        end else begin
            dwell_capture_reg <= (state_reg == S_DWELL) && tick;
            if (state_reg == S_SETTLE && !abort_in) begin
                if (settle_last) begin
                    phase_cnt_reg <= '0;
                end else if (tick) begin
                    phase_cnt_reg <= phase_cnt_reg + 1'b1;
                end
            end else if (state_reg == S_DWELL && !abort_in) begin
                if (dwell_last) begin
                    phase_cnt_reg <= '0;
                end else if (capture_en) begin
                    phase_cnt_reg <= phase_cnt_reg + 1'b1;
                end
            end else begin
                phase_cnt_reg <= '0;
            end
        end
    end

    beam_energy_acc #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_energy (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clear_in  (acc_clear),
        .enable_in (capture_en),
        .sample_in (beam_sample_in),
        .sum_out   (acc_sum)
    );

    // Strictly greater wins, so ties keep the earlier angle.
    assign win             = (acc_sum > run_best_energy_reg);
    assign new_best_energy = win ? acc_sum  : run_best_energy_reg;
    assign new_best_step   = win ? step_reg : run_best_step_reg;
    assign new_best_side   = win ? side_reg : run_best_side_reg;

    // Angle stepping, running best, and published result (only on a full sweep).
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            step_reg            <= '0;
            run_best_energy_reg <= '0;
            run_best_step_reg   <= '0;
            run_best_side_reg   <= 1'b0;
            best_energy_reg     <= '0;
            best_step_reg       <= '0;
            best_sign_reg       <= 1'b0;
        end else if ((state_reg == S_IDLE) && start_go) begin
            step_reg            <= '0;
            run_best_energy_reg <= '0;
            run_best_step_reg   <= '0;
            run_best_side_reg   <= 1'b0;
        end else if ((state_reg == S_COMPARE) && !abort_in) begin
            run_best_energy_reg <= new_best_energy;
            run_best_step_reg   <= new_best_step;
            run_best_side_reg   <= new_best_side;
            if (last_angle) begin
                best_energy_reg <= new_best_energy;
                best_step_reg   <= new_best_step;
                best_sign_reg   <= new_best_side;
            end else if (step_reg == STEP_MAX) begin
                step_reg <= STEP_W'(1);
            end else begin
                step_reg <= step_reg + 1'b1;
            end
        end
    end

    assign sin_theta_out   = SIN_WIDTH'(step_reg) << SIN_SHIFT;
    assign sign_bit_out    = side_reg;
    assign best_step_out   = best_step_reg;
    assign best_sign_out   = best_sign_reg;
    assign best_energy_out = best_energy_reg;

endmodule

// File: tb/tb_beam_scan_scheduler.sv
// Directed bench for beam_scan_scheduler with small parameters
// (4 clocks per strobe, 4 steps, 2 settle + 4 dwell strobes).
// Honors SCAN_BOTH_SIDES_EN to select the two-sided expectations.
module tb_beam_scan_scheduler;

    localparam int STEP_W = 2;

`ifdef SCAN_BOTH_SIDES_EN
    localparam int NUM_ANGLES = 7;
    localparam int NV         = 3;
`else
    localparam int NUM_ANGLES = 4;
    localparam int NV         = 4;
`endif
    // Start aligned to a strobe: first COMPARE 26 cycles in, 24 per angle, plus DONE.
    localparam int SWEEP_CYCLES = 24 * NUM_ANGLES + 3;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [15:0]       beam_sample;
    logic              tick;
    logic [16:0]       sin_theta;
    logic              sign_bit;
    logic              busy;
    logic              result_valid;
    logic [STEP_W-1:0] best_step;
    logic              best_sign;
    logic [31:0]       best_energy;

    beam_scan_scheduler #(
        .CLK_FREQ       (4000000),
        .SAMPLING_RATE  (1000000),
        .NUM_STEPS      (4),
        .SIN_WIDTH      (17),
        .SETTLE_SAMPLES (2),
        .DWELL_SAMPLES  (4),
        .ACC_WIDTH      (32)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst_n),
        .start_in         (start),
        .abort_in         (abort),
        .beam_sample_in   (beam_sample),
        .sample_tick_out  (tick),
        .sin_theta_out    (sin_theta),
        .sign_bit_out     (sign_bit),
        .busy_out         (busy),
        .result_valid_out (result_valid),
        .best_step_out    (best_step),
        .best_sign_out    (best_sign),
        .best_energy_out  (best_energy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int base;
        int alt;
        int alt_step;
        bit alt_side;
        int exp_step;
        bit exp_side;
        int exp_energy;
        bit poke_start;
    } vec_t;

    vec_t        tbl [NV];
    logic [17:0] exp_ang [NUM_ANGLES];

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus selection shared with the sample driver.
    int          base_val = 32768;
    int          alt_val  = 32768;
    logic [16:0] alt_sin  = '0;
    logic        alt_side = 1'b0;

    // Monitor state.
    logic        mon_clear = 1'b0;
    int          mon_busy;
    int          mon_res;
    int          ang_n;
    logic [17:0] last_ang;
    logic [17:0] ang_list [16];
    wire  [17:0] cur_ang = {sign_bit, sin_theta};

    task automatic check(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive the beam input: the alternate value only while the chosen angle is steered.
    always @(negedge clk) begin
        if (busy && sin_theta == alt_sin && sign_bit == alt_side) begin
            beam_sample <= 16'(alt_val);
        end else begin
            beam_sample <= 16'(base_val);
        end
    end

    // Record busy cycles, result pulses and the sequence of steered angles.
    always @(negedge clk) begin
        if (mon_clear) begin
            mon_busy <= 0;
            mon_res  <= 0;
            ang_n    <= 0;
            last_ang <= '0;
        end else begin
            if (busy) begin
                mon_busy <= mon_busy + 1;
                if ((ang_n == 0 || last_ang != cur_ang) && ang_n < 16) begin
                    ang_list[ang_n] <= cur_ang;
                    last_ang        <= cur_ang;
                    ang_n           <= ang_n + 1;
                end
            end
            if (result_valid) mon_res <= mon_res + 1;
        end
    end

    // Wait for a strobe cycle, then issue start so it is sampled at a fixed divider phase.
    task automatic start_aligned();
        int g;
        g = 0;
        while (!tick && g < 16) begin
            @(negedge clk);
            g++;
        end
        if (!tick) check("align_timeout", 0, 1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_sweep(input int idx);
        int g;
        mon_clear = 1'b1;
        @(negedge clk);
        #1 mon_clear = 1'b0;
        @(negedge clk);
        start_aligned();
        check($sformatf("v%0d_busy_after_start", idx), busy, 1);
        if (tbl[idx].poke_start) begin
            repeat (10) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        g = 0;
        while (busy && g < 3000) begin
            @(negedge clk);
            g++;
        end
        check($sformatf("v%0d_sweep_timeout", idx), busy, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int k;
        int g;
        int res_cnt;
        int busy_cnt;

`ifdef SCAN_BOTH_SIDES_EN
        tbl[0] = '{32868, 32868, 0, 1'b0, 0, 1'b0, 400,    1'b0};
        tbl[1] = '{32768, 40000, 2, 1'b1, 2, 1'b1, 28928,  1'b1};
        tbl[2] = '{32768, 0,     3, 1'b1, 3, 1'b1, 131072, 1'b0};
        exp_ang[0] = {1'b0, 17'd0};
        exp_ang[1] = {1'b0, 17'd16384};
        exp_ang[2] = {1'b0, 17'd32768};
        exp_ang[3] = {1'b0, 17'd49152};
        exp_ang[4] = {1'b1, 17'd16384};
        exp_ang[5] = {1'b1, 17'd32768};
        exp_ang[6] = {1'b1, 17'd49152};
`else
        tbl[0] = '{32868, 32868, 0, 1'b0, 0, 1'b0, 400,    1'b0};
        tbl[1] = '{32668, 0,     1, 1'b0, 1, 1'b0, 131072, 1'b0};
        tbl[2] = '{32868, 32800, 3, 1'b0, 0, 1'b0, 400,    1'b1};
        tbl[3] = '{32768, 30000, 2, 1'b0, 2, 1'b0, 11072,  1'b0};
        exp_ang[0] = {1'b0, 17'd0};
        exp_ang[1] = {1'b0, 17'd16384};
        exp_ang[2] = {1'b0, 17'd32768};
        exp_ang[3] = {1'b0, 17'd49152};
`endif

        // Reset: everything quiet, divider held at 0.
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_tick", tick, 0);
        check("rst_sin", sin_theta, 0);
        check("rst_sign", sign_bit, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result_valid, 0);
        check("rst_best_step", best_step, 0);
        check("rst_best_sign", best_sign, 0);
        check("rst_best_energy", best_energy, 0);

        // Divider: after release the count reaches 3 on the third cycle, then every 4.
        rst_n = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!tick && k < 20);
        check("first_tick_delay", k, 3);
        for (int p = 0; p < 2; p++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!tick && k < 20);
            check($sformatf("tick_period_%0d", p), k, 4);
        end

        // Table-driven full sweeps.
        for (int i = 0; i < NV; i++) begin
            base_val = tbl[i].base;
            alt_val  = tbl[i].alt;
            alt_sin  = 17'(tbl[i].alt_step) << 14;
            alt_side = tbl[i].alt_side;
            run_sweep(i);
            check($sformatf("v%0d_result_pulses", i), mon_res, 1);
            check($sformatf("v%0d_busy_cycles", i), mon_busy, SWEEP_CYCLES);
            check($sformatf("v%0d_angle_count", i), ang_n, NUM_ANGLES);
            for (int a = 0; a < NUM_ANGLES; a++) begin
                check($sformatf("v%0d_angle_%0d", i, a), ang_list[a], exp_ang[a]);
            end
            check($sformatf("v%0d_best_step", i), best_step, tbl[i].exp_step);
            check($sformatf("v%0d_best_sign", i), best_sign, tbl[i].exp_side);
            check($sformatf("v%0d_best_energy", i), best_energy, tbl[i].exp_energy);
            check($sformatf("v%0d_idle_sin_hold", i), sin_theta, 49152);
            check($sformatf("v%0d_idle_sign_hold", i), sign_bit, exp_ang[NUM_ANGLES-1][17]);
        end

        // Abort while steering step 1 on side 0.
        base_val = 32768;
        alt_val  = 0;
        alt_sin  = 17'd16384;
        alt_side = 1'b0;
        start_aligned();
        g = 0;
        while (!(busy && sin_theta == 17'd16384) && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("abort_reach_step1", sin_theta, 16384);
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 check("abort_busy_drop", busy, 0);
        abort = 1'b0;
        res_cnt = 0;
        busy_cnt = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (result_valid) res_cnt++;
            if (busy) busy_cnt++;
        end
        check("abort_no_result", res_cnt, 0);
        check("abort_stays_idle", busy_cnt, 0);
        check("abort_best_step_kept", best_step, tbl[NV-1].exp_step);
        check("abort_best_sign_kept", best_sign, tbl[NV-1].exp_side);
        check("abort_best_energy_kept", best_energy, tbl[NV-1].exp_energy);
        check("abort_sin_hold", sin_theta, 16384);

        // Start and abort together in IDLE: abort wins.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1 check("start_abort_idle_busy", busy, 0);
        start = 1'b0;
        abort = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        check("start_abort_no_sweep", busy_cnt, 0);
        check("start_abort_best_kept", best_energy, tbl[NV-1].exp_energy);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
